// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
// Receive end of the shift-register serial link. Rebuilds WIDTH-bit words
// from an MSB-first (PISO-L) or LSB-first (PISO-R) bitstream that is framed
// by frame_start and qualified per bit by sin_valid. The word is held in a
// one-entry output register with a valid/ready handshake. Overrun and
// framing errors are reported as one-cycle pulses.
//
// Optional feature: define PARITY_CHECK_EN to expect one parity bit after
// the WIDTH data bits (even parity, or odd parity with ODD_PARITY=1).
// Without the macro parity_err is tied to 0 and ODD_PARITY is ignored.
module serial_word_deserializer #(
  parameter int WIDTH      = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  input  logic             msb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             framing_err,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  shreg;
  logic              dir;         // latched msb_first of the current frame
  logic [WIDTH-1:0]  first_word;  // shift register contents after bit 0
  logic [WIDTH-1:0]  next_word;   // shift register contents after this bit
  logic              can_load;    // output register free this cycle

  // Shift-register next values and output-register availability.
  always_comb begin
    first_word = msb_first ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
    next_word  = dir ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};
    can_load   = !dout_valid || dout_ready;
  end

  // Framing FSM, shift register, output register and error pulses.
  // NOTE: all state here uses non-blocking assignments; a later assignment to
  // the same register in this block (e.g. loading dout_valid after clearing
  // it on acceptance) intentionally overrides the earlier one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      shreg       <= '0;
      dir         <= 1'b1;
      dout        <= '0;
      dout_valid  <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err  <= 1'b0;
`endif
      if (dout_valid && dout_ready)
        dout_valid <= 1'b0;

      if (sin_valid) begin
        if (frame_start) begin
          // A start strobe always begins a new word; mid-word it is an error.
          if (state != IDLE)
            framing_err <= 1'b1;
          dir   <= msb_first;
          shreg <= first_word;
          count <= CW'(1);
          state <= SHIFT;
        end else begin
          case (state)
            IDLE: begin
              // Unframed bits are ignored.
            end
            SHIFT: begin
              shreg <= next_word;
              if (count == LAST_BIT) begin
                count <= '0;
`ifdef PARITY_CHECK_EN
                state <= PARITY;
`else
                state <= IDLE;
                if (can_load) begin
                  dout       <= next_word;
                  dout_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
`endif
              end else begin
                count <= count + CW'(1);
              end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
              state <= IDLE;
              if ((^shreg ^ sin) == ODD_PARITY) begin
                if (can_load) begin
                  dout       <= shreg;
                  dout_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                parity_err <= 1'b1;
              end
            end
`endif
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

`ifndef PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer (WIDTH=4). A word-level
// reference model collects framed bits in a queue and computes the expected
// word arithmetically; every cycle all outputs are compared against it, and
// each scenario also checks the fixed values it is built around.
module tb_serial_word_deserializer;

  localparam int W   = 4;
  localparam bit ODD = 1'b0;
`ifdef PARITY_CHECK_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         msb_first = 1'b1;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b1;
  logic         overrun;
  logic         framing_err;
  logic         parity_err;

  serial_word_deserializer #(.WIDTH(W), .ODD_PARITY(ODD)) dut (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .frame_start (frame_start),
    .msb_first   (msb_first),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .overrun     (overrun),
    .framing_err (framing_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [W-1:0] m_dout  = '0;
  logic         m_valid = 1'b0;
  logic         m_over  = 1'b0;
  logic         m_fe    = 1'b0;
  logic         m_pe    = 1'b0;
  logic         m_active = 1'b0;
  logic         m_dir   = 1'b1;
  int           m_bits[$];

  int total = 0;
  int passed = 0;
  int ov_seen = 0;
  int fe_seen = 0;
  int pe_seen = 0;

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int   val;
    int   ones;
    logic ok;
    logic was_valid;
    was_valid = m_valid;
    m_over = 1'b0;
    m_fe   = 1'b0;
    m_pe   = 1'b0;
    if (reset) begin
      m_dout = '0; m_valid = 1'b0; m_active = 1'b0; m_dir = 1'b1;
      m_bits.delete();
      return;
    end
    if (was_valid && dout_ready) m_valid = 1'b0;
    if (sin_valid) begin
      if (frame_start) begin
        if (m_active) m_fe = 1'b1;
        m_bits.delete();
        m_bits.push_back(int'(sin));
        m_dir = msb_first;
        m_active = 1'b1;
      end else if (m_active) begin
        m_bits.push_back(int'(sin));
      end
      if (m_active && m_bits.size() == NB) begin
        val = 0;
        ones = 0;
        for (int i = 0; i < W; i++) begin
          if (m_dir) val = val * 2 + m_bits[i];
          else       val = val + (m_bits[i] << i);
        end
        for (int i = 0; i < NB; i++) ones += m_bits[i];
        ok = (NB == W) || ((ones % 2) == int'(ODD));
        if (!ok) m_pe = 1'b1;
        else if (!was_valid || dout_ready) begin
          m_dout = val[W-1:0];
          m_valid = 1'b1;
        end else m_over = 1'b1;
        m_active = 1'b0;
        m_bits.delete();
      end
    end
  endtask

  // One clock: update model, let the edge pass, compare all outputs.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    total++;
    if (dout_valid !== m_valid) $display("FAIL dout_valid t=%0t got %b want %b", $time, dout_valid, m_valid);
    else passed++;
    total++;
    if (m_valid && dout !== m_dout) $display("FAIL dout t=%0t got %0d want %0d", $time, dout, m_dout);
    else if (!m_valid && reset && dout !== '0) $display("FAIL dout_reset t=%0t got %0d want 0", $time, dout);
    else passed++;
    total++;
    if (overrun !== m_over) $display("FAIL overrun t=%0t got %b want %b", $time, overrun, m_over);
    else passed++;
    total++;
    if (framing_err !== m_fe) $display("FAIL framing_err t=%0t got %b want %b", $time, framing_err, m_fe);
    else passed++;
    total++;
    if (parity_err !== m_pe) $display("FAIL parity_err t=%0t got %b want %b", $time, parity_err, m_pe);
    else passed++;
    if (overrun === 1'b1) ov_seen++;
    if (framing_err === 1'b1) fe_seen++;
    if (parity_err === 1'b1) pe_seen++;
  endtask

  task automatic drive(input logic v, input logic s, input logic fs, input logic m, input logic r);
    sin_valid = v; sin = s; frame_start = fs; msb_first = m; dout_ready = r;
    step();
  endtask

  // Send one framed word (plus parity bit when enabled) with `gap` idle
  // cycles between bits; rdy_last is dout_ready on the final bit.
  task automatic send_word(input int value, input logic msb, input int gap,
                           input logic rdy, input logic rdy_last, input logic par_flip);
    logic [W-1:0] d;
    logic         b;
    logic         last;
    d = value[W-1:0];
    for (int i = 0; i < NB; i++) begin
      if (i < W) b = msb ? d[W-1-i] : d[i];
      else       b = (^d) ^ ODD ^ par_flip;
      last = (i == NB - 1);
      drive(1'b1, b, i == 0, msb, last ? rdy_last : rdy);
      if (!last) repeat (gap) drive(1'b0, 1'b0, 1'b0, msb, rdy);
    end
  endtask

  task automatic clear_seen();
    ov_seen = 0; fe_seen = 0; pe_seen = 0;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    clear_seen();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if ({dout, dout_valid, overrun, framing_err, parity_err} !== '0)
      $display("FAIL reset_outputs got %b want 0", {dout, dout_valid, overrun, framing_err, parity_err});
    else passed++;
    reset = 1'b0;
    drain();
  endtask

  task automatic test_msb_first();
    drain();
    send_word(13, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    total++;
    if (dout_valid !== 1'b1 || dout !== 4'd13) $display("FAIL msb_word got %0d/%b want 13/1", dout, dout_valid);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (dout_valid !== 1'b0) $display("FAIL msb_valid_len got %b want 0", dout_valid);
    else passed++;
  endtask

  task automatic test_lsb_first();
    drain();
    send_word(8, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    total++;
    if (dout !== 4'd8 || dout_valid !== 1'b1 || ov_seen + fe_seen + pe_seen != 0)
      $display("FAIL lsb_word got %0d/%b errs %0d want 8/1 errs 0", dout, dout_valid, ov_seen + fe_seen + pe_seen);
    else passed++;
  endtask

  task automatic test_overrun();
    drain();
    send_word(9, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    send_word(6, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ov_seen != 1 || dout !== 4'd9 || dout_valid !== 1'b1)
      $display("FAIL overrun_drop got ov=%0d dout=%0d v=%b want ov=1 dout=9 v=1", ov_seen, dout, dout_valid);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (dout_valid !== 1'b0 || ov_seen != 1) $display("FAIL overrun_accept got v=%b ov=%0d want v=0 ov=1", dout_valid, ov_seen);
    else passed++;
  endtask

  task automatic test_back_to_back();
    drain();
    send_word(9, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    send_word(6, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    total++;
    if (ov_seen != 0 || dout !== 4'd6 || dout_valid !== 1'b1)
      $display("FAIL b2b got ov=%0d dout=%0d v=%b want ov=0 dout=6 v=1", ov_seen, dout, dout_valid);
    else passed++;
  endtask

  task automatic test_framing();
    drain();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_word(10, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    total++;
    if (fe_seen != 1 || dout !== 4'd10 || dout_valid !== 1'b1)
      $display("FAIL framing got fe=%0d dout=%0d v=%b want fe=1 dout=10 v=1", fe_seen, dout, dout_valid);
    else passed++;
  endtask

  task automatic test_mid_reset();
    drain();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if ({dout, dout_valid, overrun, framing_err, parity_err} !== '0)
      $display("FAIL mid_reset got %b want 0", {dout, dout_valid, overrun, framing_err, parity_err});
    else passed++;
    reset = 1'b0;
    clear_seen();
    send_word(7, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    total++;
    if (dout !== 4'd7 || dout_valid !== 1'b1 || ov_seen + fe_seen + pe_seen != 0)
      $display("FAIL after_reset got %0d/%b errs %0d want 7/1 errs 0", dout, dout_valid, ov_seen + fe_seen + pe_seen);
    else passed++;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    drain();
    send_word(13, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    total++;
    if (dout !== 4'd13 || dout_valid !== 1'b1 || pe_seen != 0)
      $display("FAIL parity_good got %0d/%b pe=%0d want 13/1 pe=0", dout, dout_valid, pe_seen);
    else passed++;
    drain();
    send_word(13, 1'b1, 0, 1'b1, 1'b1, 1'b1);
    total++;
    if (pe_seen != 1 || dout_valid !== 1'b0 || ov_seen != 0)
      $display("FAIL parity_bad got pe=%0d v=%b ov=%0d want pe=1 v=0 ov=0", pe_seen, dout_valid, ov_seen);
    else passed++;
  endtask
`endif

  task automatic test_random();
    logic v;
    logic fs;
    drain();
    for (int c = 0; c < 3000; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = v && (m_active ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0));
      drive(v, 1'($urandom_range(0, 1)), fs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_framing();
    test_mid_reset();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
- Receive end of the shift-register serial link: collects a bitstream produced by a PISO-L (MSB-first) or PISO-R (LSB-first) shifter and rebuilds parallel words.
- Frame alignment via a start strobe, per-bit valid qualifier, one-entry output register with valid/ready handshake, overrun and framing error reporting.
- Sits between the serial pin logic and the parallel consumer in the shift-register datapath.

Parameters:
- WIDTH, 4, data bits per word; legal values are 2 to 32.
- ODD_PARITY, 0, parity sense when PARITY_CHECK_EN is defined: 0 means even, 1 means odd. Ignored otherwise.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this cycle only when this is 1.
- frame_start  input  1  qualified by sin_valid; marks the current bit as bit 0 of a new word.
- msb_first  input  1  1 means MSB-first (PISO-L order), 0 means LSB-first (PISO-R order); sampled only on a frame_start bit.
- dout  output  WIDTH  received word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both 1.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- framing_err  output  1  one-cycle pulse: frame_start arrived mid-word.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without the macro.

Behaviour:
- Reset, synchronous and active-high, takes priority over every other input:
  - state goes to IDLE; bit counter and shift register are cleared; the latched direction is set to 1.
  - dout=0, dout_valid=0, overrun=0, framing_err=0, parity_err=0.
  - A partial word in progress is discarded; no error pulse is generated.
- States are IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- IDLE:
  - Bits with sin_valid=1 and frame_start=0 are ignored.
  - sin_valid=1 with frame_start=1: latch msb_first, shift in sin, set count=1, go to SHIFT.
  - If WIDTH is reached on that bit (not possible for WIDTH>=2), treat it as word complete.
- SHIFT, on each sin_valid=1:
  - MSB-first: shreg <= {shreg[WIDTH-2:0], sin}.
  - LSB-first: shreg <= {sin, shreg[WIDTH-1:1]}.
  - count increments.
  - When the WIDTH-th bit is accepted, the word is complete: return to IDLE, or go to PARITY with the macro.
- frame_start=1 with sin_valid=1 while in SHIFT or PARITY:
  - framing_err pulses on the next cycle.
  - The partial word is discarded.
  - The current bit restarts the frame as bit 0, with msb_first re-latched.
- sin_valid=0: shift register, counter and state all hold. There is no timeout.
- Word delivery:
  - On completion cycle N, the word is written to dout at edge N and dout_valid=1 from cycle N+1. Latency is one cycle after the last bit is sampled.
  - Delivery requires either dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle (the old word is drained and the new word loaded with no bubble).
  - Otherwise the new word is dropped, overrun pulses for one cycle, and dout and dout_valid are unchanged.
- Handshake:
  - dout_valid clears on acceptance unless a new word loads in the same cycle.
  - dout is stable while dout_valid=1 and dout_ready=0.
- Error pulses last exactly one cycle each and may coincide with each other.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY and the next sin_valid bit is the parity bit.
  - Even parity: XOR of the data bits plus the parity bit must be 0. ODD_PARITY=1: it must be 1.
  - On a match, the word is delivered as described above, with completion at the parity bit.
  - On a mismatch, the word is discarded, parity_err pulses for one cycle, and overrun is not raised.
- Undefined:
  - No PARITY state; the word completes at the WIDTH-th bit.
  - parity_err is tied to 0.

Test Plan:
- All scenarios use WIDTH=4.
- MSB-first frame with bits 1,1,0,1 (frame_start on the first bit), dout_ready=1 → dout=13, dout_valid high for exactly 1 cycle, starting the cycle after the 4th bit.
- LSB-first frame with bits 0,0,0,1, sin_valid toggling every other cycle → dout=8, no errors.
- dout_ready=0; frames of 9 then 6 → overrun pulses once at completion of 6; dout stays 9 with dout_valid=1. Raise dout_ready → one accept, then dout_valid=0.
- dout_valid=1 (word 9) and dout_ready=1 on the completion cycle of word 6 → no overrun; dout=6 on the next cycle with dout_valid still 1.
- frame_start after 2 bits of a frame, then 4 bits 1,0,1,0 MSB-first → framing_err pulses once; dout=10.
- reset asserted after 3 bits, then a full frame 0,1,1,1 MSB-first → outputs all 0 during reset; afterwards dout=7 with no error pulses.
- With PARITY_CHECK_EN and ODD_PARITY=0:
  - 1,1,0,1 plus parity bit 1 → dout=13.
  - 1,1,0,1 plus parity bit 0 → parity_err pulses and dout_valid stays 0.
